arith_op_scheduler: RTL
=======================

# arith_op_scheduler

Round-robin scheduler that shares one set of 16-bit arithmetic units (floating add, floating multiply, fixed add, fixed multiply) between `NREQ` requesters. It accepts one operation at a time, drives the shared operand buses, and registers the selected result and overflow flag. It returns them on a valid/ready response channel tagged with the requester index. It sits between the requesting front-ends (switch/button capture or a host port) and the combinational operator instances, replacing per-requester operator copies.

## Interface
- `NREQ`, 2 — number of requesters; legal range 2..4.
- `W`, 16 — operand/result width.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_ready`  out  NREQ  grant/accept, at most one bit high (one-hot or zero).
- `req_op`  in  2*NREQ  op per requester: 00 float add, 01 float mult, 10 fixed add, 11 fixed mult. Requester i uses bits [2i+1:2i].
- `req_a`, `req_b`  in  W*NREQ  operands; requester i uses bits [W*i+W-1:W*i].
- `dp_num1`, `dp_num2`  out  W  registered operands to all operator units.
- `dp_res_fla`, `dp_res_flm`, `dp_res_fia`, `dp_res_fim`  in  W each  operator results.
- `dp_of_fla`, `dp_of_flm`, `dp_of_fia`, `dp_of_fim`  in  1 each  operator overflow flags.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  W  selected result.
- `rsp_overflow`  out  1  selected overflow.
- `rsp_id`  out  2  index of requester served.
- `rsp_op`  out  2  op code served.
- `busy`  out  1  high in EXEC and RESP.

## Operation
- States: IDLE, EXEC, RESP.
- **IDLE**
  - `req_ready` is combinational. The bit for the winner is high when any `req_valid` is high; all bits are 0 otherwise.
  - Winner: the first requester with `req_valid` high, searching upward from `rr_ptr` with wrap (`rr_ptr`, `rr_ptr`+1, … mod NREQ).
  - On accept (`req_valid[g] & req_ready[g]`):
    - latch `dp_num1`←a[g], `dp_num2`←b[g], `op_q`←op[g], `id_q`←g;
    - set `rr_ptr` ← (g+1) mod NREQ;
    - go to EXEC.
- **EXEC**
  - One settling cycle for the combinational operators. `req_ready` is all 0.
  - At the end of EXEC, capture:
    - `rsp_data`/`rsp_overflow` from the unit selected by `op_q` (00→fla, 01→flm, 10→fia, 11→fim);
    - `rsp_id`←`id_q`, `rsp_op`←`op_q`, `rsp_valid`←1.
  - Go to RESP.
- **RESP**
  - Hold all `rsp_*` outputs and `dp_num1`/`dp_num2` stable. `req_ready` is all 0.
  - On `rsp_valid & rsp_ready`: `rsp_valid`←0, go to IDLE.
- New requests are never accepted in EXEC or RESP. `req_valid` changes there have no effect.
- A requester that drops `req_valid` before being granted loses nothing; no state is kept per requester.
- Op and operands are sampled only at the accept edge. Later changes on `req_*` do not affect an in-flight operation.
- `rsp_data`/`rsp_overflow` pass through from the datapath with no width change or saturation. Overflow is the selected unit's flag only.

## Timing
- Reset values (asserted asynchronously):
  - state IDLE, `rr_ptr` 0;
  - `dp_num1`/`dp_num2` 0, `op_q`/`id_q` 0;
  - `rsp_valid` 0, `rsp_data` 0, `rsp_overflow` 0, `rsp_id` 0, `rsp_op` 0;
  - `busy` 0.
- `req_ready` is 0 while `rst` is high.
- Latency: accept at edge k, then `rsp_valid` high after edge k+2. With `rsp_ready` held high, `rsp_valid` drops after edge k+3. The next accept is possible at edge k+4 (IDLE entered after k+3, so `req_ready` is seen during cycle k+3..k+4). Peak throughput is one op per 4 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle, chosen by the rotating priority above.
- Wrap: after granting requester NREQ-1, `rr_ptr` = 0.
- Reset mid-EXEC/RESP: the operation is discarded and `rsp_valid` drops immediately. `rr_ptr` returns to 0.
- `rsp_ready` high while `rsp_valid` is low is ignored.

## Test plan
- **Routing.** Bench drives the datapath with constants fla=0xA001/of 0, flm=0xB002/of 1, fia=0xC003/of 0, fim=0xD004/of 1. Requester 0 issues each op 00..11 in turn → `rsp_data` = 0xA001, 0xB002, 0xC003, 0xD004 and `rsp_overflow` = 0,1,0,1, with `rsp_id`=0 and `rsp_op` matching each.
- **Operand latch and latency.** Requester 1 issues op 10 with a=0x0003, b=0x0004 through a real fixed adder, accepted at edge k; `req_a` is changed to 0xFFFF at k+1 → `dp_num1`=0x0003 and `rsp_data`=0x0007, with `rsp_valid` first high after edge k+2.
- **Round robin.** NREQ=3 with all `req_valid` held high for 6 operations and `rsp_ready`=1 → grant order 0,1,2,0,1,2 and `rsp_id` in the same order; `req_ready` never has more than one bit set.
- **Backpressure.** Hold `rsp_ready`=0 for 10 cycles after `rsp_valid` rises → `rsp_*` stable, `busy`=1, `req_ready`=0 throughout. Release `rsp_ready` → `rsp_valid` low after the next edge, then the next request is granted.
- **Reset mid-operation.** Pulse `rst` asynchronously (between edges) during RESP → `rsp_valid`, `busy` and `dp_num1` go to 0 without a clock edge. After release, with requesters 1 and 0 both valid, requester 0 is granted first (`rr_ptr` back to 0).

Source files
------------

// File: rtl/arith_op_scheduler.sv
// arith_op_scheduler
// Round-robin front end that time-shares one set of 16-bit arithmetic units
// (float add, float mult, fixed add, fixed mult) between NREQ requesters.
// One operation is in flight at a time. Operands are latched on accept and
// the selected result is returned on a valid/ready response channel.
module arith_op_scheduler #(
    parameter int NREQ = 2,
    parameter int W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [2*NREQ-1:0]   req_op,
    input  logic [W*NREQ-1:0]   req_a,
    input  logic [W*NREQ-1:0]   req_b,
    output logic [W-1:0]        dp_num1,
    output logic [W-1:0]        dp_num2,
    input  logic [W-1:0]        dp_res_fla,
    input  logic [W-1:0]        dp_res_flm,
    input  logic [W-1:0]        dp_res_fia,
    input  logic [W-1:0]        dp_res_fim,
    input  logic                dp_of_fla,
    input  logic                dp_of_flm,
    input  logic                dp_of_fia,
    input  logic                dp_of_fim,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [W-1:0]        rsp_data,
    output logic                rsp_overflow,
    output logic [1:0]          rsp_id,
    output logic [1:0]          rsp_op,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic            settle_r;
    logic [1:0]      rr_ptr_r;
    logic [1:0]      next_rr_ptr_s;
    logic [W-1:0]    num1_r;
    logic [W-1:0]    num2_r;
    logic [1:0]      op_r;
    logic [1:0]      id_r;
    logic            rsp_valid_r;
    logic [W-1:0]    rsp_data_r;
    logic            rsp_overflow_r;
    logic [1:0]      rsp_id_r;
    logic [1:0]      rsp_op_r;
    logic            busy_r;

    logic            grant_found_s;
    logic [1:0]      grant_idx_s;
    int              cand_s;
    logic [NREQ-1:0] req_ready_s;
    logic [W-1:0]    a_sel_s;
    logic [W-1:0]    b_sel_s;
    logic [1:0]      op_sel_s;
    logic [W-1:0]    res_sel_s;
    logic            of_sel_s;
    logic            accept_s;
    logic            capture_s;
    logic            release_s;

    // Rotating-priority search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = 2'b00;
        cand_s        = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = int'(rr_ptr_r) + k;
            if (cand_s >= NREQ) begin
                cand_s = cand_s - NREQ;
            end else begin
                cand_s = cand_s;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_found_s && (cand_s == i) && req_valid[i]) begin
                    grant_found_s = 1'b1;
                    grant_idx_s   = 2'(i);
                end else begin
                    grant_found_s = grant_found_s;
                end
            end
        end
    end

    // One-hot grant, only offered in IDLE and never while reset is asserted.
    always_comb begin
        req_ready_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!rst && (state_r == IDLE) && grant_found_s && (grant_idx_s == 2'(i))) begin
                req_ready_s[i] = 1'b1;
            end else begin
                req_ready_s[i] = 1'b0;
            end
        end
    end

    // Mux the winner's op and operands onto the latch inputs.
    always_comb begin
        a_sel_s  = '0;
        b_sel_s  = '0;
        op_sel_s = 2'b00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx_s == 2'(i)) begin
                a_sel_s  = req_a[W*i +: W];
                b_sel_s  = req_b[W*i +: W];
                op_sel_s = req_op[2*i +: 2];
            end else begin
                a_sel_s  = a_sel_s;
            end
        end
    end

    // Pointer advances past the granted requester, wrapping at NREQ-1.
    always_comb begin
        if (grant_idx_s == 2'(NREQ - 1)) begin
            next_rr_ptr_s = 2'b00;
        end else begin
            next_rr_ptr_s = grant_idx_s + 2'b01;
        end
    end

    // Pick the result and overflow of the unit addressed by the latched op.
    always_comb begin
        res_sel_s = dp_res_fla;
        of_sel_s  = dp_of_fla;
        case (op_r)
            2'b00:   begin res_sel_s = dp_res_fla; of_sel_s = dp_of_fla; end
            2'b01:   begin res_sel_s = dp_res_flm; of_sel_s = dp_of_flm; end
            2'b10:   begin res_sel_s = dp_res_fia; of_sel_s = dp_of_fia; end
            2'b11:   begin res_sel_s = dp_res_fim; of_sel_s = dp_of_fim; end
            default: begin res_sel_s = dp_res_fla; of_sel_s = dp_of_fla; end
        endcase
    end

    // Next-state and datapath enables. EXEC spans two edges: the first lets the
    // freshly registered operands ripple through the operators, the second captures.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_found_s) begin
                    next_state_s = EXEC;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EXEC: begin
                if (settle_r) begin
                    next_state_s = RESP;
                    capture_s    = 1'b1;
                end else begin
                    next_state_s = EXEC;
                end
            end
            RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    next_state_s = IDLE;
                    release_s    = 1'b1;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register, EXEC settle flag and registered busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            settle_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            settle_r <= (state_r == EXEC) && (next_state_s == EXEC);
            busy_r   <= (next_state_s != IDLE);
        end
    end

    // Accept-time latches: operands, op, requester id and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num1_r   <= '0;
            num2_r   <= '0;
            op_r     <= 2'b00;
            id_r     <= 2'b00;
            rr_ptr_r <= 2'b00;
        end else if (accept_s) begin
            num1_r   <= a_sel_s;
            num2_r   <= b_sel_s;
            op_r     <= op_sel_s;
            id_r     <= grant_idx_s;
            rr_ptr_r <= next_rr_ptr_s;
        end
    end

    // Response channel registers: loaded at the end of EXEC, cleared on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r    <= 1'b0;
            rsp_data_r     <= '0;
            rsp_overflow_r <= 1'b0;
            rsp_id_r       <= 2'b00;
            rsp_op_r       <= 2'b00;
        end else if (capture_s) begin
            rsp_valid_r    <= 1'b1;
            rsp_data_r     <= res_sel_s;
            rsp_overflow_r <= of_sel_s;
            rsp_id_r       <= id_r;
            rsp_op_r       <= op_r;
        end else if (release_s) begin
            rsp_valid_r    <= 1'b0;
        end
    end

    assign req_ready    = req_ready_s;
    assign dp_num1      = num1_r;
    assign dp_num2      = num2_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_data     = rsp_data_r;
    assign rsp_overflow = rsp_overflow_r;
    assign rsp_id       = rsp_id_r;
    assign rsp_op       = rsp_op_r;
    assign busy         = busy_r;

endmodule
